// File: rtl/cg_vector_memory_if.sv
// Control-unit bus for one banked CG vector store (X, P or R): primary read/write,
// snapshot control, prev-bank read and sticky error reporting.
interface cg_vector_memory_if #(
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 20
);
    localparam int unsigned DATA_WIDTH = NO_OF_UNITS * ELEMENT_WIDTH;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_oob;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  snap_start;
    logic                  snap_busy;
    logic                  snap_done;
    logic                  prev_rd_en;
    logic [ADDR_WIDTH-1:0] prev_rd_addr;
    logic [DATA_WIDTH-1:0] prev_rd_data;
    logic                  prev_rd_valid;
    logic [1:0]            err_flags;
    logic                  clear_err;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, snap_start,
               prev_rd_en, prev_rd_addr, clear_err,
        input  rd_data, rd_valid, rd_oob, wr_ready, snap_busy, snap_done,
               prev_rd_data, prev_rd_valid, err_flags
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, snap_start,
               prev_rd_en, prev_rd_addr, clear_err,
        output rd_data, rd_valid, rd_oob, wr_ready, snap_busy, snap_done,
               prev_rd_data, prev_rd_valid, err_flags
    );
endinterface

// File: rtl/cg_vector_memory.sv
// Banked CG vector store with 2-cycle read pipelines, a snapshot engine into a prev bank
// and sticky errors. Define CG_MEM_BYPASS_EN for write-to-read forwarding on the primary port.
module cg_vector_memory #(
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned ADDR_WIDTH    = 20
) (
    input logic              clk,
    input logic              reset,
    cg_vector_memory_if.slave bus
);
    localparam int unsigned DATA_WIDTH = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             busy_d, done_d, ready_d;
    logic [1:0]       err_d;

    logic [DATA_WIDTH-1:0] mem  [DEPTH];
    logic [DATA_WIDTH-1:0] prev [DEPTH];

    logic             rd_s1_valid, rd_s1_oob;
    logic [IDX_W-1:0] rd_s1_idx;
    logic             pv_s1_valid, pv_s1_oob;
    logic [IDX_W-1:0] pv_s1_idx;
    logic             wr_ok;
    logic             rd_fwd;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a < ADDR_WIDTH'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a);
    endfunction

    // Accepted, in-range write; reset suppresses any commit.
    assign wr_ok = bus.wr_en && bus.wr_ready && !reset && in_range(bus.wr_addr);

`ifdef CG_MEM_BYPASS_EN
    assign rd_fwd = wr_ok && !rd_s1_oob && (to_idx(bus.wr_addr) == rd_s1_idx);
`else
    assign rd_fwd = 1'b0;
`endif

    // Arrays are never reset; the copy stops immediately when reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[to_idx(bus.wr_addr)] <= bus.wr_data;
        end
        if (!reset && state_q == COPY) begin
            prev[ptr_q] <= mem[ptr_q];
        end
    end

    // Primary read pipeline: stage 1 holds the address, stage 2 loads the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1_valid  <= 1'b0;
            rd_s1_oob    <= 1'b0;
            rd_s1_idx    <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_oob   <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            rd_s1_valid  <= bus.rd_en;
            rd_s1_oob    <= !in_range(bus.rd_addr);
            rd_s1_idx    <= to_idx(bus.rd_addr);
            bus.rd_valid <= rd_s1_valid;
            bus.rd_oob   <= rd_s1_valid && rd_s1_oob;
            if (rd_s1_valid) begin
                bus.rd_data <= rd_s1_oob ? '0 : (rd_fwd ? bus.wr_data : mem[rd_s1_idx]);
            end
        end
    end

    // Prev-bank read pipeline, same timing, no forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_s1_valid       <= 1'b0;
            pv_s1_oob         <= 1'b0;
            pv_s1_idx         <= '0;
            bus.prev_rd_valid <= 1'b0;
            bus.prev_rd_data  <= '0;
        end else begin
            pv_s1_valid       <= bus.prev_rd_en;
            pv_s1_oob         <= !in_range(bus.prev_rd_addr);
            pv_s1_idx         <= to_idx(bus.prev_rd_addr);
            bus.prev_rd_valid <= pv_s1_valid;
            if (pv_s1_valid) begin
                bus.prev_rd_data <= pv_s1_oob ? '0 : prev[pv_s1_idx];
            end
        end
    end

    // Snapshot FSM next state, registered status outputs and sticky error update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.snap_start) begin
                    state_d = COPY;
                    ptr_d   = '0;
                end
            end
            COPY: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = DONE;
                    ptr_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == COPY);
        done_d  = (state_d == DONE);
        ready_d = (state_d != COPY);

        // A new error in the same cycle as clear_err keeps its flag set.
        err_d = bus.clear_err ? 2'b00 : bus.err_flags;
        if ((bus.rd_en && !in_range(bus.rd_addr)) ||
            (bus.prev_rd_en && !in_range(bus.prev_rd_addr)) ||
            (bus.wr_en && bus.wr_ready && !in_range(bus.wr_addr))) begin
            err_d[0] = 1'b1;
        end
        if (bus.wr_en && !bus.wr_ready) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            bus.snap_busy <= 1'b0;
            bus.snap_done <= 1'b0;
            bus.wr_ready  <= 1'b1;
            bus.err_flags <= 2'b00;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            bus.snap_busy <= busy_d;
            bus.snap_done <= done_d;
            bus.wr_ready  <= ready_d;
            bus.err_flags <= err_d;
        end
    end
endmodule

// File: tb/tb_cg_vector_memory.sv
// Scoreboard bench for cg_vector_memory: stimulus queues expected read words, a negedge
// monitor pops and compares them whenever rd_valid / prev_rd_valid is presented.
module tb_cg_vector_memory;
    localparam int unsigned NU    = 8;
    localparam int unsigned EW    = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = NU * EW;

    localparam logic [DW-1:0] W_AA = {32{8'hAA}};
    localparam logic [DW-1:0] W_55 = {32{8'h55}};
`ifdef CG_MEM_BYPASS_EN
    localparam logic [DW-1:0] BYP_EXP = {32{8'h55}};
`else
    localparam logic [DW-1:0] BYP_EXP = 256'h2;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          oob;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cg_vector_memory_if #(.NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();

    cg_vector_memory #(
        .NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    rd_exp_t       rd_q[$];
    logic [DW-1:0] prev_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input logic oob);
        rd_exp_t e;
        e.data = exp;
        e.oob  = oob;
        rd_q.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic prd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        prev_q.push_back(exp);
        bus.prev_rd_en   = 1'b1;
        bus.prev_rd_addr = addr;
        tick();
        bus.prev_rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
    endtask

    // Monitor: compare every presented read against the oldest expectation.
    initial begin : monitor
        rd_exp_t       e;
        logic [DW-1:0] pe;
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got rd_valid=1, expected no pending read");
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", bus.rd_data, e.data);
                    check("rd_oob", DW'(bus.rd_oob), DW'(e.oob));
                end
            end
            if (bus.prev_rd_valid === 1'b1) begin
                if (prev_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL prev_unexpected: got prev_rd_valid=1, expected no pending read");
                end else begin
                    pe = prev_q.pop_front();
                    check("prev_rd_data", bus.prev_rd_data, pe);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic saw_done;
        rd_exp_t e;
        reset            = 1'b1;
        bus.rd_en        = 1'b0;
        bus.rd_addr      = '0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.snap_start   = 1'b0;
        bus.prev_rd_en   = 1'b0;
        bus.prev_rd_addr = '0;
        bus.clear_err    = 1'b0;
        idle(2);

        check("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
        check("rst_rd_oob", DW'(bus.rd_oob), DW'(0));
        check("rst_rd_data", bus.rd_data, '0);
        check("rst_prev_valid", DW'(bus.prev_rd_valid), DW'(0));
        check("rst_prev_data", bus.prev_rd_data, '0);
        check("rst_busy", DW'(bus.snap_busy), DW'(0));
        check("rst_done", DW'(bus.snap_done), DW'(0));
        check("rst_err", DW'(bus.err_flags), DW'(0));
        check("rst_wr_ready", DW'(bus.wr_ready), DW'(1));
        reset = 1'b0;

        wr(20'd0, 256'h1);
        wr(20'd1, 256'h2);
        wr(20'd2, 256'h3);

        // Two-cycle latency on the first read.
        e.data = 256'h2;
        e.oob  = 1'b0;
        rd_q.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 20'd1;
        tick();
        bus.rd_en = 1'b0;
        @(negedge clk);
        check("rd_lat_n1", DW'(bus.rd_valid), DW'(0));
        tick();
        @(negedge clk);
        check("rd_lat_n2", DW'(bus.rd_valid), DW'(1));

        rd(20'd0, 256'h1, 1'b0);
        rd(20'd2, 256'h3, 1'b0);
        idle(3);

        // Out-of-range read.
        rd(20'd3, '0, 1'b1);
        idle(2);
        check("oob_err", DW'(bus.err_flags), DW'(2'b01));
        clear_errors();
        check("oob_clear", DW'(bus.err_flags), DW'(2'b00));

        // Snapshot; snap_start held into COPY is ignored; write during COPY dropped.
        bus.snap_start = 1'b1;
        tick();
        check("snap_busy_c0", DW'(bus.snap_busy), DW'(1));
        check("snap_wr_ready_c0", DW'(bus.wr_ready), DW'(0));
        bus.wr_en   = 1'b1;
        bus.wr_addr = 20'd0;
        bus.wr_data = 256'h99;
        tick();
        bus.snap_start = 1'b0;
        bus.wr_en      = 1'b0;
        check("drop_err", DW'(bus.err_flags), DW'(2'b10));
        check("snap_busy_c1", DW'(bus.snap_busy), DW'(1));
        tick();
        check("snap_busy_c2", DW'(bus.snap_busy), DW'(1));
        tick();
        check("snap_busy_done", DW'(bus.snap_busy), DW'(0));
        check("snap_done_pulse", DW'(bus.snap_done), DW'(1));
        tick();
        check("snap_done_end", DW'(bus.snap_done), DW'(0));
        check("snap_busy_end", DW'(bus.snap_busy), DW'(0));
        check("snap_wr_ready_end", DW'(bus.wr_ready), DW'(1));
        prd(20'd0, 256'h1);
        prd(20'd1, 256'h2);
        prd(20'd2, 256'h3);
        rd(20'd0, 256'h1, 1'b0);
        idle(3);
        clear_errors();
        check("snap_clear", DW'(bus.err_flags), DW'(2'b00));

        // snap_start together with an accepted write.
        bus.snap_start = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 20'd2;
        bus.wr_data    = W_AA;
        check("snapwr_ready", DW'(bus.wr_ready), DW'(1));
        tick();
        bus.snap_start = 1'b0;
        bus.wr_en      = 1'b0;
        idle(4);
        check("snapwr_noerr", DW'(bus.err_flags), DW'(2'b00));
        prd(20'd2, W_AA);
        prd(20'd0, 256'h1);
        rd(20'd2, W_AA, 1'b0);
        idle(3);

        // Write to the stage-1 read address in the following cycle.
        e.data = BYP_EXP;
        e.oob  = 1'b0;
        rd_q.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 20'd1;
        tick();
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 20'd1;
        bus.wr_data = W_55;
        tick();
        bus.wr_en = 1'b0;
        rd(20'd1, W_55, 1'b0);
        idle(3);

        // Out-of-range write is discarded, no wrap onto address 0.
        wr(20'd3, 256'h77);
        idle(1);
        check("wr_oob_err", DW'(bus.err_flags), DW'(2'b01));
        rd(20'd0, 256'h1, 1'b0);
        rd(20'd1, W_55, 1'b0);
        rd(20'd2, W_AA, 1'b0);
        idle(3);
        clear_errors();
        prd(20'd5, '0);
        idle(3);
        check("prev_oob_err", DW'(bus.err_flags), DW'(2'b01));
        clear_errors();

        // clear_err in the same cycle as a new error: the error wins.
        e.data = '0;
        e.oob  = 1'b1;
        rd_q.push_back(e);
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 20'd4;
        bus.clear_err = 1'b1;
        tick();
        bus.rd_en     = 1'b0;
        bus.clear_err = 1'b0;
        check("clear_vs_err", DW'(bus.err_flags), DW'(2'b01));
        idle(3);
        clear_errors();

        // Reset while COPY is at ptr=1.
        wr(20'd0, 256'h11);
        wr(20'd1, 256'h22);
        wr(20'd2, 256'h33);
        bus.snap_start = 1'b1;
        tick();
        bus.snap_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rstcopy_busy", DW'(bus.snap_busy), DW'(0));
        check("rstcopy_done", DW'(bus.snap_done), DW'(0));
        check("rstcopy_wr_ready", DW'(bus.wr_ready), DW'(1));
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.snap_done === 1'b1) saw_done = 1'b1;
        end
        check("rstcopy_no_done", DW'(saw_done), DW'(0));
        prd(20'd0, 256'h11);
        prd(20'd1, 256'h2);
        prd(20'd2, W_AA);
        rd(20'd0, 256'h11, 1'b0);
        idle(3);

        for (int i = 0; i < 20 && (rd_q.size() != 0 || prev_q.size() != 0); i++) tick();
        check("drain_rd", DW'(rd_q.size()), DW'(0));
        check("drain_prev", DW'(prev_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
